controller_buff_param: RTL and testbench

Parametrised successor to the fixed 64-bit × 8-entry controller/buffer pair. It combines internal circular storage with a read controller, so no separate buffer instance is needed. Writes land in the buffer in arrival order. A prefill threshold gates streaming start-up, and words are then drained through a registered valid/ready output. The block sits between the upstream producer (64-bit words, write strobe) and the downstream consumer, replacing the `state==0` gate and the fixed 3-pulse start-up with a real handshake, full/overflow flags and a configurable start threshold.

---
 rtl/controller_buff_param.sv | 137 +++++++++++++
 tb/tb_controller_buff_param.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/controller_buff_param.sv
// controller_buff_param: circular word buffer with a prefill-gated read
// controller and a registered valid/ready output stage.
// Optional feature macro: CBUF_REFILL_EN -- when defined, a fully drained
// buffer drops back to FILL so the start threshold is reapplied.
module controller_buff_param #(
    parameter int unsigned DATA_W    = 64,
    parameter int unsigned DEPTH     = 8,
    parameter int unsigned START_LVL = 3,
    localparam int unsigned AW       = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              we_in,
    input  logic [DATA_W-1:0] in_data,
    output logic              full,
    output logic              ovf,
    output logic [AW:0]       level,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              v_flag,
    output logic              oe_flag,
    output logic [AW-1:0]     addr_out_flag
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FILL   = 2'd1,
        STREAM = 2'd2
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [AW:0]       level_nxt;
    logic              wr_acc;
    logic              pop;

    assign addr_out_flag = rd_ptr;

    // Write acceptance and pop decision for the current cycle
    always_comb begin
        wr_acc = 1'b0;
        pop    = 1'b0;
        if (!rst && en) begin
            wr_acc = we_in && !full;
            pop    = (state == STREAM) && (level != '0) && (!v_flag || out_ready);
        end
    end

    // Next storage level: simultaneous write and pop cancel out
    always_comb begin
        level_nxt = level;
        case ({wr_acc, pop})
            2'b10:   level_nxt = level + (AW+1)'(1);
            2'b01:   level_nxt = level - (AW+1)'(1);
            default: level_nxt = level;
        endcase
    end

    // Next-state logic: en low forces IDLE, prefill threshold gates STREAM
    always_comb begin
        state_nxt = state;
        if (!en) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE: state_nxt = FILL;
                FILL: begin
                    if (level >= (AW+1)'(START_LVL)) begin
                        state_nxt = STREAM;
                    end
                end
                STREAM: begin
`ifdef CBUF_REFILL_EN
                    if ((level == '0) && (!v_flag || out_ready)) begin
                        state_nxt = FILL;
                    end
`else
                    state_nxt = STREAM;
`endif
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Storage array; contents intentionally survive reset and flush
    always_ff @(posedge clk) begin
        if (wr_acc) begin
            mem[wr_ptr] <= in_data;
        end
    end

    // Pointers, level/flags and the registered output stage
    always_ff @(posedge clk) begin
        if (rst || !en) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            level    <= '0;
            full     <= 1'b0;
            ovf      <= 1'b0;
            v_flag   <= 1'b0;
            out_data <= '0;
            oe_flag  <= 1'b0;
        end else begin
            if (wr_acc) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (we_in && full) begin
                ovf <= 1'b1;
            end
            level   <= level_nxt;
            full    <= (level_nxt == (AW+1)'(DEPTH));
            oe_flag <= (state_nxt == STREAM);
            if (pop) begin
                out_data <= mem[rd_ptr];
                rd_ptr   <= rd_ptr + AW'(1);
                v_flag   <= 1'b1;
            end else if (v_flag && out_ready) begin
                v_flag <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_controller_buff_param.sv
// Directed self-checking bench for controller_buff_param (default parameters).
module tb_controller_buff_param;

    logic        clk;
    logic        rst;
    logic        en;
    logic        we_in;
    logic [63:0] in_data;
    logic        full;
    logic        ovf;
    logic [3:0]  level;
    logic        out_ready;
    logic [63:0] out_data;
    logic        v_flag;
    logic        oe_flag;
    logic [2:0]  addr_out_flag;

    int n_checks = 0;
    int n_fail   = 0;

    controller_buff_param dut (
        .clk           (clk),
        .rst           (rst),
        .en            (en),
        .we_in         (we_in),
        .in_data       (in_data),
        .full          (full),
        .ovf           (ovf),
        .level         (level),
        .out_ready     (out_ready),
        .out_data      (out_data),
        .v_flag        (v_flag),
        .oe_flag       (oe_flag),
        .addr_out_flag (addr_out_flag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock; sample point is 1 time unit after the edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] wd(input logic [15:0] tag, input int i);
        return {tag, 48'(i)};
    endfunction

    // One cycle with en low, then confirm everything is cleared
    task automatic flush();
        en    = 1'b0;
        we_in = 1'b0;
        tick();
        chk("flush_level", 64'(level), 64'd0);
        chk("flush_full", 64'(full), 64'd0);
        chk("flush_ovf", 64'(ovf), 64'd0);
        chk("flush_v", 64'(v_flag), 64'd0);
        chk("flush_oe", 64'(oe_flag), 64'd0);
        chk("flush_addr", 64'(addr_out_flag), 64'd0);
        chk("flush_data", out_data, 64'd0);
    endtask

    initial begin
        rst       = 1'b1;
        en        = 1'b0;
        we_in     = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        tick();
        chk("rst_data", out_data, 64'd0);
        chk("rst_v", 64'(v_flag), 64'd0);
        chk("rst_oe", 64'(oe_flag), 64'd0);
        chk("rst_addr", 64'(addr_out_flag), 64'd0);
        chk("rst_level", 64'(level), 64'd0);
        chk("rst_full", 64'(full), 64'd0);
        chk("rst_ovf", 64'(ovf), 64'd0);

        // Start-up: three writes reach the threshold, W0 visible two cycles later
        en        = 1'b1;
        out_ready = 1'b1;
        we_in     = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_data = wd(16'hA000, i);
            tick();
            chk("start_level", 64'(level), 64'(i + 1));
        end
        chk("start_oe_lo", 64'(oe_flag), 64'd0);
        we_in = 1'b0;
        tick();
        chk("start_oe_hi", 64'(oe_flag), 64'd1);
        chk("start_v_lo", 64'(v_flag), 64'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("start_v", 64'(v_flag), 64'd1);
            chk("start_data", out_data, wd(16'hA000, i));
        end
        tick();
        chk("start_v_end", 64'(v_flag), 64'd0);
        chk("start_data_hold", out_data, wd(16'hA000, 2));

        // Backpressure: B0 held while out_ready low, then B1..B3 back to back
        flush();
        en        = 1'b1;
        out_ready = 1'b0;
        we_in     = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_data = wd(16'hB000, i);
            tick();
        end
        we_in = 1'b0;
        tick();
        for (int k = 0; k < 5; k++) begin
            chk("bp_data", out_data, wd(16'hB000, 0));
            chk("bp_v", 64'(v_flag), 64'd1);
            chk("bp_level", 64'(level), 64'd3);
            tick();
        end
        out_ready = 1'b1;
        for (int i = 1; i < 4; i++) begin
            tick();
            chk("bp_rel_v", 64'(v_flag), 64'd1);
            chk("bp_rel_data", out_data, wd(16'hB000, i));
        end
        tick();
        chk("bp_end_v", 64'(v_flag), 64'd0);
        chk("bp_end_level", 64'(level), 64'd0);

        // Overflow: one word parks in the output register, so storage fills
        // on the 9th write and the 10th/11th writes are dropped
        flush();
        en        = 1'b1;
        out_ready = 1'b0;
        we_in     = 1'b1;
        for (int i = 0; i < 11; i++) begin
            in_data = wd(16'hC000, i);
            tick();
            if (i == 8) begin
                chk("ovf_full", 64'(full), 64'd1);
                chk("ovf_level8", 64'(level), 64'd8);
                chk("ovf_not_yet", 64'(ovf), 64'd0);
            end
            if (i == 9) begin
                chk("ovf_set", 64'(ovf), 64'd1);
                chk("ovf_level_hold", 64'(level), 64'd8);
            end
        end
        we_in = 1'b0;
        chk("ovf_head", out_data, wd(16'hC000, 0));
        chk("ovf_head_v", 64'(v_flag), 64'd1);
        out_ready = 1'b1;
        for (int i = 1; i < 9; i++) begin
            tick();
            chk("ovf_drain", out_data, wd(16'hC000, i));
            chk("ovf_drain_v", 64'(v_flag), 64'd1);
        end
        tick();
        chk("ovf_dropped_v", 64'(v_flag), 64'd0);
        chk("ovf_sticky", 64'(ovf), 64'd1);

        // Wrap-around: 20 words with concurrent write and pop
        flush();
        en        = 1'b1;
        out_ready = 1'b1;
        for (int c = 0; c < 24; c++) begin
            we_in   = (c < 20);
            in_data = wd(16'hD000, c);
            tick();
            if (c + 1 >= 5) begin
                chk("wrap_v", 64'(v_flag), 64'd1);
                chk("wrap_data", out_data, wd(16'hD000, c - 4));
                chk("wrap_addr", 64'(addr_out_flag), 64'((c - 3) % 8));
                chk("wrap_level", 64'(level), (c + 1 <= 20) ? 64'd4 : 64'(23 - c));
            end
        end
        tick();
        chk("wrap_end_v", 64'(v_flag), 64'd0);

        // Flush mid-stream with v_flag high and five words stored
        flush();
        en        = 1'b1;
        out_ready = 1'b0;
        we_in     = 1'b1;
        for (int i = 0; i < 6; i++) begin
            in_data = wd(16'hE000, i);
            tick();
        end
        we_in = 1'b0;
        chk("mid_v", 64'(v_flag), 64'd1);
        chk("mid_level", 64'(level), 64'd5);
        chk("mid_data", out_data, wd(16'hE000, 0));
        flush();
        en        = 1'b1;
        out_ready = 1'b1;
        we_in     = 1'b1;
        for (int i = 0; i < 2; i++) begin
            in_data = wd(16'hF000, i);
            tick();
        end
        we_in = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("restart_oe_lo", 64'(oe_flag), 64'd0);
            chk("restart_v_lo", 64'(v_flag), 64'd0);
            chk("restart_level", 64'(level), 64'd2);
        end
        we_in   = 1'b1;
        in_data = wd(16'hF000, 2);
        tick();
        we_in = 1'b0;
        chk("restart_level3", 64'(level), 64'd3);
        chk("restart_oe_still_lo", 64'(oe_flag), 64'd0);
        tick();
        chk("restart_oe_hi", 64'(oe_flag), 64'd1);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("restart_v", 64'(v_flag), 64'd1);
            chk("restart_data", out_data, wd(16'hF000, i));
        end
        tick();
        chk("drained_v", 64'(v_flag), 64'd0);
`ifdef CBUF_REFILL_EN
        chk("drained_oe", 64'(oe_flag), 64'd0);
`else
        chk("drained_oe", 64'(oe_flag), 64'd1);
`endif

        // Refill: one word written into the drained buffer
        we_in   = 1'b1;
        in_data = wd(16'h5000, 0);
        tick();
        we_in = 1'b0;
        chk("refill_level", 64'(level), 64'd1);
        tick();
`ifdef CBUF_REFILL_EN
        chk("refill_v_lo", 64'(v_flag), 64'd0);
        chk("refill_oe_lo", 64'(oe_flag), 64'd0);
        chk("refill_level_hold", 64'(level), 64'd1);
        we_in = 1'b1;
        for (int i = 1; i < 3; i++) begin
            in_data = wd(16'h5000, i);
            tick();
        end
        we_in = 1'b0;
        chk("refill_level3", 64'(level), 64'd3);
        tick();
        chk("refill_oe_hi", 64'(oe_flag), 64'd1);
        tick();
        chk("refill_v", 64'(v_flag), 64'd1);
        chk("refill_data", out_data, wd(16'h5000, 0));
`else
        chk("refill_v", 64'(v_flag), 64'd1);
        chk("refill_data", out_data, wd(16'h5000, 0));
        chk("refill_level0", 64'(level), 64'd0);
        chk("refill_oe", 64'(oe_flag), 64'd1);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
